lectura_datos_vga: RTL and testbench

Reads the 160x120 RGB332 frame buffer that the OV7670 capture path fills, and drives a 640x480@60 Hz VGA monitor. It sits on the read port (port B) of the dual-port frame RAM: it generates VGA sync timing, issues RAM read addresses, and scales each stored pixel up 4x4. Each stored pixel is expanded to RGB444 for the VGA DAC.

---
 rtl/lectura_datos_vga_pkg.sv | 44 ++++
 rtl/lectura_datos_vga_if.sv | 36 +++
 rtl/vga_sync_gen.sv | 58 +++++
 rtl/lectura_datos_vga.sv | 111 +++++++++++
 tb/tb_lectura_datos_vga.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/lectura_datos_vga_pkg.sv
// rtl/lectura_datos_vga_pkg.sv - shared VGA timing, image size and RGB332 layout (VGA_PATTERN_EN adds bar index)
package lectura_datos_vga_pkg;

    localparam int IMG_W      = 160;
    localparam int IMG_H      = 120;
    localparam int SCALE_LOG2 = 2;
    localparam int AW         = 15;
    localparam int CW         = 10;

    localparam logic [CW-1:0] H_ACT_DEF  = 10'd640;
    localparam logic [CW-1:0] H_FP_DEF   = 10'd16;
    localparam logic [CW-1:0] H_SYNC_DEF = 10'd96;
    localparam logic [CW-1:0] H_BP_DEF   = 10'd48;
    localparam logic [CW-1:0] H_TOTAL    = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam logic [CW-1:0] V_ACT_DEF  = 10'd480;
    localparam logic [CW-1:0] V_FP_DEF   = 10'd10;
    localparam logic [CW-1:0] V_SYNC_DEF = 10'd2;
    localparam logic [CW-1:0] V_BP_DEF   = 10'd33;
    localparam logic [CW-1:0] V_TOTAL    = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // RGB332 layout {R[2:0],G[2:0],B[1:0]}: MSB position of each field
    localparam int R_MSB = 7;
    localparam int G_MSB = 4;
    localparam int B_MSB = 1;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       fe;
`ifdef VGA_PATTERN_EN
        logic [2:0] bar;
`endif
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, default: '0};

    // Replicate the high bits into the low bits so full-scale codes map to 0xF
    function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
        return {d[R_MSB -: 3], d[R_MSB], d[G_MSB -: 3], d[G_MSB], d[B_MSB -: 2], d[B_MSB -: 2]};
    endfunction

endpackage

// File: rtl/lectura_datos_vga_if.sv
// rtl/lectura_datos_vga_if.sv - frame RAM read port and VGA output bundle (VGA_PATTERN_EN adds PATTERN)
interface lectura_datos_vga_if;
    import lectura_datos_vga_pkg::*;

    logic [7:0]    DP_RAM_data_out;
    logic [AW-1:0] DP_RAM_addr_out;
    logic          VGA_HS;
    logic          VGA_VS;
    logic [3:0]    VGA_R;
    logic [3:0]    VGA_G;
    logic [3:0]    VGA_B;
    logic          FRAME_END;

`ifdef VGA_PATTERN_EN
    logic          PATTERN;

    modport master (
        input  DP_RAM_data_out, PATTERN,
        output DP_RAM_addr_out, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, FRAME_END
    );
    modport slave (
        output DP_RAM_data_out, PATTERN,
        input  DP_RAM_addr_out, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, FRAME_END
    );
`else
    modport master (
        input  DP_RAM_data_out,
        output DP_RAM_addr_out, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, FRAME_END
    );
    modport slave (
        output DP_RAM_data_out,
        input  DP_RAM_addr_out, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, FRAME_END
    );
`endif

endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - hc/vc raster counters with raw (undelayed) HS/VS/active decode
module vga_sync_gen
    import lectura_datos_vga_pkg::*;
#(
    parameter logic [CW-1:0] H_ACT  = H_ACT_DEF,
    parameter logic [CW-1:0] H_FP   = H_FP_DEF,
    parameter logic [CW-1:0] H_SYNC = H_SYNC_DEF,
    parameter logic [CW-1:0] H_BP   = H_BP_DEF,
    parameter logic [CW-1:0] V_ACT  = V_ACT_DEF,
    parameter logic [CW-1:0] V_FP   = V_FP_DEF,
    parameter logic [CW-1:0] V_SYNC = V_SYNC_DEF,
    parameter logic [CW-1:0] V_BP   = V_BP_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [CW-1:0] hc_o,
    output logic [CW-1:0] vc_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          active_o
);

    localparam logic [CW-1:0] HS_START = H_ACT + H_FP;
    localparam logic [CW-1:0] HS_END   = HS_START + H_SYNC;
    localparam logic [CW-1:0] H_LAST   = HS_END + H_BP - CW'(1);
    localparam logic [CW-1:0] VS_START = V_ACT + V_FP;
    localparam logic [CW-1:0] VS_END   = VS_START + V_SYNC;
    localparam logic [CW-1:0] V_LAST   = VS_END + V_BP - CW'(1);

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;

    always_comb begin
        hc_d = hc_q + CW'(1);
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc_o     = hc_q;
    assign vc_o     = vc_q;
    assign hs_o     = !((hc_q >= HS_START) && (hc_q < HS_END));
    assign vs_o     = !((vc_q >= VS_START) && (vc_q < VS_END));
    assign active_o = (hc_q < H_ACT) && (vc_q < V_ACT);

endmodule

// File: rtl/lectura_datos_vga.sv
// rtl/lectura_datos_vga.sv - frame buffer reader: 4x4 upscale to 640x480 VGA, 3-clock aligned pipeline (VGA_PATTERN_EN adds colour bars)
module lectura_datos_vga
    import lectura_datos_vga_pkg::*;
#(
    parameter logic [CW-1:0] H_ACT  = H_ACT_DEF,
    parameter logic [CW-1:0] H_FP   = H_FP_DEF,
    parameter logic [CW-1:0] H_SYNC = H_SYNC_DEF,
    parameter logic [CW-1:0] H_BP   = H_BP_DEF,
    parameter logic [CW-1:0] V_ACT  = V_ACT_DEF,
    parameter logic [CW-1:0] V_FP   = V_FP_DEF,
    parameter logic [CW-1:0] V_SYNC = V_SYNC_DEF,
    parameter logic [CW-1:0] V_BP   = V_BP_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    lectura_datos_vga_if.master vga
);

    logic [CW-1:0] hc, vc;
    logic          hs_raw, vs_raw, act_raw;

    vga_sync_gen #(
        .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_sync (
        .clk_i    (CLK),
        .rst_i    (RST),
        .hc_o     (hc),
        .vc_o     (vc),
        .hs_o     (hs_raw),
        .vs_o     (vs_raw),
        .active_o (act_raw)
    );

    logic [AW-1:0] addr_q, addr_d;
    vga_ctl_t      ctl_d, s1_q, s2_q;
    logic          hs_q, vs_q, fe_q;
    logic [11:0]   rgb_q, rgb_d;

`ifdef VGA_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = H_ACT >> 3;

    function automatic logic [2:0] bar_of(input logic [CW-1:0] h);
        bar_of = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h >= CW'(k) * BAR_W) bar_of = 3'(k);
        end
    endfunction
`endif

    always_comb begin
        ctl_d     = CTL_IDLE;
        ctl_d.hs  = hs_raw;
        ctl_d.vs  = vs_raw;
        ctl_d.act = act_raw;
        ctl_d.fe  = (hc == '0) && (vc == V_ACT);
`ifdef VGA_PATTERN_EN
        ctl_d.bar = bar_of(hc);
`endif
        // Blanking keeps the last address so the RAM port sees no spurious reads
        addr_d = addr_q;
        if (act_raw) begin
            addr_d = AW'(vc >> SCALE_LOG2) * AW'(IMG_W) + AW'(hc >> SCALE_LOG2);
        end
    end

    // RAM data for the pixel in s2 arrives this cycle
    always_comb begin
        rgb_d = '0;
        if (s2_q.act) begin
`ifdef VGA_PATTERN_EN
            if (vga.PATTERN) begin
                rgb_d = {{4{s2_q.bar[2]}}, {4{s2_q.bar[1]}}, {4{s2_q.bar[0]}}};
            end else begin
                rgb_d = rgb332_to_444(vga.DP_RAM_data_out);
            end
`else
            rgb_d = rgb332_to_444(vga.DP_RAM_data_out);
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q <= '0;
            s1_q   <= CTL_IDLE;
            s2_q   <= CTL_IDLE;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            fe_q   <= 1'b0;
            rgb_q  <= '0;
        end else begin
            addr_q <= addr_d;
            s1_q   <= ctl_d;
            s2_q   <= s1_q;
            hs_q   <= s2_q.hs;
            vs_q   <= s2_q.vs;
            fe_q   <= s2_q.fe;
            rgb_q  <= rgb_d;
        end
    end

    assign vga.DP_RAM_addr_out = addr_q;
    assign vga.VGA_HS          = hs_q;
    assign vga.VGA_VS          = vs_q;
    assign vga.FRAME_END       = fe_q;
    assign vga.VGA_R           = rgb_q[11:8];
    assign vga.VGA_G           = rgb_q[7:4];
    assign vga.VGA_B           = rgb_q[3:0];

endmodule

// File: tb/tb_lectura_datos_vga.sv
// tb/tb_lectura_datos_vga.sv - scoreboard bench for lectura_datos_vga with a shortened vertical frame
module tb_lectura_datos_vga;
    import lectura_datos_vga_pkg::*;

    localparam int TB_V_ACT  = 16;
    localparam int TB_V_FP   = 2;
    localparam int TB_V_SYNC = 2;
    localparam int TB_V_BP   = 3;
    localparam int TB_V_TOT  = TB_V_ACT + TB_V_FP + TB_V_SYNC + TB_V_BP;
    localparam int TB_IMG_H  = TB_V_ACT / 4;
    localparam int FRAME     = 800 * TB_V_TOT;
    localparam logic [14:0] IDLE_V = {1'b1, 1'b1, 1'b0, 12'h000};

    logic clk = 1'b0;
    logic rst;

    lectura_datos_vga_if bus();

    lectura_datos_vga #(
        .V_ACT  (10'(TB_V_ACT)),
        .V_FP   (10'(TB_V_FP)),
        .V_SYNC (10'(TB_V_SYNC)),
        .V_BP   (10'(TB_V_BP))
    ) dut (
        .CLK (clk),
        .RST (rst),
        .vga (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]    mem [0:32767];
    logic [14:0]   sb_q [$];
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] ram_addr;
    int  n_cmp = 0;
    int  n_err = 0;
    int  m_hc, m_vc, cyc;
    int  hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
    int  fe_first = -1, fe_last = -1, fe_cnt = 0, max_addr = 0;
    bit  measure = 1'b1;
    bit  pat = 1'b0;
    logic prev_hs, prev_vs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d hc %0d vc %0d)", tag, got, exp, cyc, m_hc, m_vc);
        end
    endtask

    task automatic set_pattern(input bit b);
        pat = b;
`ifdef VGA_PATTERN_EN
        bus.PATTERN = b;
`endif
    endtask

    function automatic logic [14:0] exp_video(input int h, input int v, input bit p);
        logic hs, vs, fe;
        logic [11:0] rgb;
        logic [7:0] d;
        int k;
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= TB_V_ACT + TB_V_FP && v < TB_V_ACT + TB_V_FP + TB_V_SYNC);
        fe  = (h == 0 && v == TB_V_ACT);
        rgb = 12'h000;
        if (h < 640 && v < TB_V_ACT) begin
            if (p) begin
                k   = h / 80;
                rgb = {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
            end else begin
                d   = mem[(v / 4) * 160 + h / 4];
                rgb = {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
            end
        end
        return {hs, vs, fe, rgb};
    endfunction

    task automatic step();
        logic [14:0] got, e;
        @(negedge clk);
        got = {bus.VGA_HS, bus.VGA_VS, bus.FRAME_END, bus.VGA_R, bus.VGA_G, bus.VGA_B};
        e   = sb_q.pop_front();
        check_eq("video", 32'(got), 32'(e));
        check_eq("addr", 32'(bus.DP_RAM_addr_out), 32'(exp_addr));
        if (!rst && measure) begin
            if (prev_hs && !bus.VGA_HS && hs_fall < 0) hs_fall = cyc;
            if (!prev_hs && bus.VGA_HS && hs_fall >= 0 && hs_rise < 0) hs_rise = cyc;
            if (prev_vs && !bus.VGA_VS && vs_fall < 0) vs_fall = cyc;
            if (!prev_vs && bus.VGA_VS && vs_fall >= 0 && vs_rise < 0) vs_rise = cyc;
            if (bus.FRAME_END) begin
                fe_cnt++;
                if (fe_first < 0) fe_first = cyc;
                fe_last = cyc;
            end
            case (cyc)
                3:  check_eq("rgb_E0", 32'(got[11:0]), 32'h0F00);
                7:  check_eq("rgb_1C", 32'(got[11:0]), 32'h00F0);
                11: check_eq("rgb_03", 32'(got[11:0]), 32'h000F);
                15: check_eq("rgb_FF", 32'(got[11:0]), 32'h0FFF);
                default: ;
            endcase
        end
        prev_hs = bus.VGA_HS;
        prev_vs = bus.VGA_VS;
        if (int'(bus.DP_RAM_addr_out) > max_addr) max_addr = int'(bus.DP_RAM_addr_out);
        ram_addr = bus.DP_RAM_addr_out;
        if (rst) begin
            sb_q.delete();
            repeat (3) sb_q.push_back(IDLE_V);
            exp_addr = '0;
            m_hc = 0;
            m_vc = 0;
            cyc  = 0;
        end else begin
            sb_q.push_back(exp_video(m_hc, m_vc, pat));
            if (m_hc < 640 && m_vc < TB_V_ACT) exp_addr = AW'((m_vc / 4) * 160 + m_hc / 4);
            m_hc++;
            if (m_hc == 800) begin
                m_hc = 0;
                m_vc++;
                if (m_vc == TB_V_TOT) m_vc = 0;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.DP_RAM_data_out = mem[ram_addr];
    endtask

    task automatic run_until(input int h, input int v, input int budget);
        int n;
        n = 0;
        while (!(m_hc == h && m_vc == v) && n < budget) begin
            step();
            n++;
        end
        check_eq("reach_hv", 32'(m_hc == h && m_vc == v), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        set_pattern(1'b0);
        bus.DP_RAM_data_out = 8'h00;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0;
        mem[1] = 8'h1C;
        mem[2] = 8'h03;
        mem[3] = 8'hFF;
        repeat (3) sb_q.push_back(IDLE_V);
        exp_addr = '0;
        m_hc = 0;
        m_vc = 0;
        cyc  = 0;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        @(posedge clk);
        #1;

        repeat (5) step();
        rst = 1'b0;
        repeat (2 * FRAME) step();
        measure = 1'b0;

        check_eq("hs_fall", 32'(hs_fall), 32'd659);
        check_eq("hs_rise", 32'(hs_rise), 32'd755);
        check_eq("vs_fall", 32'(vs_fall), 32'((TB_V_ACT + TB_V_FP) * 800 + 3));
        check_eq("vs_rise", 32'(vs_rise), 32'((TB_V_ACT + TB_V_FP + TB_V_SYNC) * 800 + 3));
        check_eq("fe_first", 32'(fe_first), 32'(TB_V_ACT * 800 + 3));
        check_eq("fe_count", 32'(fe_cnt), 32'd2);
        check_eq("fe_period", 32'(fe_last - fe_first), 32'(FRAME));
        check_eq("max_addr", 32'(max_addr), 32'(160 * TB_IMG_H - 1));

`ifdef VGA_PATTERN_EN
        run_until(700, 0, FRAME);
        set_pattern(1'b1);
        run_until(700, 1, 1000);
        set_pattern(1'b0);
`endif

        run_until(300, 10, FRAME);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("addr_after_rst", 32'(bus.DP_RAM_addr_out), 32'd0);
        check_eq("hs_after_rst", 32'(bus.VGA_HS), 32'd1);
        repeat (2000) step();
        check_eq("max_addr_final", 32'(max_addr), 32'(160 * TB_IMG_H - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
